// File: rtl/sync_bistable_bank.sv
// Bank of clocked bistables replacing cross-coupled-inverter latches.
// Async set/clear are synchronized and rising-edge detected; sw pulses act directly.
module sync_bistable_bank #(
  parameter int unsigned          CHANNELS    = 8,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]  RESET_VAL   = '0,
  parameter int unsigned          CONFLICT    = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] set_in_i,
  input  logic [CHANNELS-1:0] clr_in_i,
  input  logic [CHANNELS-1:0] sw_set_i,
  input  logic [CHANNELS-1:0] sw_clr_i,
  input  logic [CHANNELS-1:0] ack_i,
  output logic [CHANNELS-1:0] q_o,
  output logic [CHANNELS-1:0] qn_o,
  output logic [CHANNELS-1:0] chg_o,
  output logic [CHANNELS-1:0] sticky_o
);

  logic [CHANNELS-1:0] set_sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] clr_sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] set_dly_q, clr_dly_q;
  logic [CHANNELS-1:0] set_evt, clr_evt;
  logic [CHANNELS-1:0] set_req, clr_req;
  logic [CHANNELS-1:0] q_d, q_q;
  logic [CHANNELS-1:0] chg_d, chg_q;
  logic [CHANNELS-1:0] sticky_d, sticky_q;

  // Synchronizers and edge-detect delay flops; reset discards in-flight events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        set_sync_q[s] <= '0;
        clr_sync_q[s] <= '0;
      end
      set_dly_q <= '0;
      clr_dly_q <= '0;
    end else begin
      set_sync_q[0] <= set_in_i;
      clr_sync_q[0] <= clr_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        set_sync_q[s] <= set_sync_q[s-1];
        clr_sync_q[s] <= clr_sync_q[s-1];
      end
      set_dly_q <= set_sync_q[SYNC_STAGES-1];
      clr_dly_q <= clr_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    set_evt = set_sync_q[SYNC_STAGES-1] & ~set_dly_q;
    clr_evt = clr_sync_q[SYNC_STAGES-1] & ~clr_dly_q;
    set_req = set_evt | sw_set_i;
    clr_req = clr_evt | sw_clr_i;
  end

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({set_req[i], clr_req[i]})
        2'b10: q_d[i] = 1'b1;
        2'b01: q_d[i] = 1'b0;
        2'b11: begin
          // Mode 3 (hold) leaves the default in place.
          if (CONFLICT == 0) begin
            q_d[i] = 1'b1;
          end else if (CONFLICT == 1) begin
            q_d[i] = 1'b0;
          end else if (CONFLICT == 2) begin
            q_d[i] = ~q_q[i];
          end
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // A change in the same cycle as ack keeps the sticky bit set.
  always_comb begin
    chg_d    = q_d ^ q_q;
    sticky_d = chg_d | (sticky_q & ~ack_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q      <= RESET_VAL;
      chg_q    <= '0;
      sticky_q <= '0;
    end else begin
      q_q      <= q_d;
      chg_q    <= chg_d;
      sticky_q <= sticky_d;
    end
  end

  assign q_o      = q_q;
  assign qn_o     = ~q_q;
  assign chg_o    = chg_q;
  assign sticky_o = sticky_q;

endmodule

// File: tb/tb_sync_bistable_bank.sv
// Directed bench for sync_bistable_bank: four instances, one per conflict mode,
// sharing stimulus; vector table plus hand-written latency/reset sequences.
module tb_sync_bistable_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] set_in = '0, clr_in = '0, sw_set = '0, sw_clr = '0, ack = '0;
  logic [7:0] q [4];
  logic [7:0] qn [4];
  logic [7:0] chg [4];
  logic [7:0] sticky [4];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sync_bistable_bank #(
      .CHANNELS   (8),
      .SYNC_STAGES(2),
      .RESET_VAL  (8'hA5),
      .CONFLICT   (g)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .set_in_i(set_in),
      .clr_in_i(clr_in),
      .sw_set_i(sw_set),
      .sw_clr_i(sw_clr),
      .ack_i   (ack),
      .q_o     (q[g]),
      .qn_o    (qn[g]),
      .chg_o   (chg[g]),
      .sticky_o(sticky[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw_set;
    logic [7:0] sw_clr;
    logic [7:0] ack;
    logic [7:0] q;
    logic [7:0] chg;
    logic [7:0] sticky;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complementary outputs on every instance, every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) chk($sformatf("qn_inv%0d", i), qn[i], ~q[i]);
  end

  initial begin
    //           sw_set  sw_clr  ack     q       chg     sticky
    vecs[0]  = '{8'h01, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};  // redundant set
    vecs[1]  = '{8'h00, 8'h01, 8'h00, 8'hA4, 8'h01, 8'h01};
    vecs[2]  = '{8'h00, 8'h00, 8'h00, 8'hA4, 8'h00, 8'h01};
    vecs[3]  = '{8'h00, 8'h00, 8'h01, 8'hA4, 8'h00, 8'h00};
    vecs[4]  = '{8'h0A, 8'h00, 8'h00, 8'hAE, 8'h0A, 8'h0A};
    vecs[5]  = '{8'h00, 8'h08, 8'h08, 8'hA6, 8'h08, 8'h0A};  // ack loses to change
    vecs[6]  = '{8'h00, 8'h00, 8'h08, 8'hA6, 8'h00, 8'h02};
    vecs[7]  = '{8'h01, 8'h01, 8'h00, 8'hA7, 8'h01, 8'h03};  // conflict, set wins
    vecs[8]  = '{8'h00, 8'h80, 8'h03, 8'h27, 8'h80, 8'h80};
    vecs[9]  = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hD8, 8'hD8};
    vecs[10] = '{8'h00, 8'hF0, 8'hFF, 8'h0F, 8'hF0, 8'hF0};
    vecs[11] = '{8'h00, 8'h00, 8'hF0, 8'h0F, 8'h00, 8'h00};

    // T1: reset values, and stability after release with no events
    repeat (2) tick();
    chk("rst_q", q[0], 8'hA5);
    chk("rst_qn", qn[0], 8'h5A);
    chk("rst_chg", chg[0], 8'h00);
    chk("rst_sticky", sticky[0], 8'h00);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_q", q[0], 8'hA5);
      chk("post_rst_chg", chg[0], 8'h00);
    end

    // Sync path vector table
    foreach (vecs[i]) begin
      sw_set = vecs[i].sw_set;
      sw_clr = vecs[i].sw_clr;
      ack    = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d_q", i), q[0], vecs[i].q);
      chk($sformatf("vec%0d_chg", i), chg[0], vecs[i].chg);
      chk($sformatf("vec%0d_sticky", i), sticky[0], vecs[i].sticky);
    end
    sw_set = '0; sw_clr = '0; ack = '0;

    // T2: async set latency (edge k sample -> q at edge k+2)
    sw_clr = 8'hFF; tick(); sw_clr = '0;
    ack = 8'hFF; tick(); ack = '0;
    chk("t2_pre_q", q[0], 8'h00);
    chk("t2_pre_sticky", sticky[0], 8'h00);
    set_in = 8'h08;
    tick();                                   // edge k
    chk("t2_k_q", q[0], 8'h00);
    tick();                                   // edge k+1
    chk("t2_k1_q", q[0], 8'h00);
    tick();                                   // edge k+2
    chk("t2_k2_q", q[0], 8'h08);
    chk("t2_k2_chg", chg[0], 8'h08);
    chk("t2_k2_sticky", sticky[0], 8'h08);
    tick();
    chk("t2_k3_q", q[0], 8'h08);
    chk("t2_k3_chg", chg[0], 8'h00);
    // Async clear with the same latency
    set_in = '0;
    clr_in = 8'h08;
    tick(); tick();
    chk("t2_clr_k1_q", q[0], 8'h08);
    tick();
    chk("t2_clr_k2_q", q[0], 8'h00);
    chk("t2_clr_k2_chg", chg[0], 8'h08);
    clr_in = '0;
    ack = 8'hFF; tick(); ack = '0;

    // T3: sync clear one-cycle latency, redundant set gives no chg
    sw_set = 8'h09; tick(); sw_set = '0;
    sw_clr = 8'h08; tick(); sw_clr = '0;
    chk("t3_clr_q", q[0], 8'h01);
    chk("t3_clr_chg", chg[0], 8'h08);
    sw_set = 8'h01; tick(); sw_set = '0;
    chk("t3_redund_q", q[0], 8'h01);
    chk("t3_redund_chg", chg[0], 8'h00);

    // T4: conflict modes, starting from q[0]=0 everywhere
    sw_clr = 8'hFF; tick(); sw_clr = '0;
    sw_set = 8'h01; sw_clr = 8'h01; tick();
    chk("t4_m0_a", q[0] & 8'h01, 8'h01);
    chk("t4_m1_a", q[1] & 8'h01, 8'h00);
    chk("t4_m2_a", q[2] & 8'h01, 8'h01);
    chk("t4_m3_a", q[3] & 8'h01, 8'h00);
    tick();
    sw_set = '0; sw_clr = '0;
    chk("t4_m0_b", q[0] & 8'h01, 8'h01);
    chk("t4_m1_b", q[1] & 8'h01, 8'h00);
    chk("t4_m2_b", q[2] & 8'h01, 8'h00);
    chk("t4_m3_b", q[3] & 8'h01, 8'h00);
    chk("t4_m2_chg", chg[2], 8'h01);

    // T6: set_in[1] held across reset counts as an edge, 3 edges after release
    set_in = 8'h02;
    rst_n  = 1'b0;
    tick(); tick();
    chk("t6_in_rst_q", q[0], 8'hA5);
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_e2_q", q[0], 8'hA5);
    tick();
    chk("t6_e3_q", q[0], 8'hA7);
    chk("t6_e3_chg", chg[0], 8'h02);
    set_in = '0;
    tick(); tick();

    // Reset mid-synchronization: event discarded, outputs return at once
    set_in = 8'h40;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_q", q[0], 8'hA5);
    chk("abort_chg", chg[0], 8'h00);
    chk("abort_sticky", sticky[0], 8'h00);
    set_in = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("abort_post_q", q[0], 8'hA5);
      chk("abort_post_chg", chg[0], 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
